jk_drive_ctrl: RTL and testbench

JK_DRIVE_CTRL -- requirements
Module: jk_drive_ctrl

---
 rtl/jk_drive_ctrl.sv | 92 +++++++++
 tb/tb_jk_drive_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_drive_ctrl.sv
// Sequencer that drives an external bank of JK flip-flops to a requested value,
// verifies the result through q_fb, retries a bounded number of times, then flags error.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// DRIVE | j/k excitation presented for one cycle
// CHECK | bank settled, q_fb compared to target on exit
// ERR   | retries exhausted, err held until err_clr
module jk_drive_ctrl #(
  parameter int WIDTH      = 4,
  parameter int MAX_RETRY  = 3,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ERR} state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [RW-1:0]    retry;

  // Returns {j, k} that move q toward t in one clock of the external flops.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] q);
    if (USE_TOGGLE != 0) return {t ^ q, t ^ q};
    else                 return {t & ~q, ~t & q};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      target <= '0;
      retry  <= '0;
      j      <= '0;
      k      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      j    <= '0;
      k    <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target <= req_data;
            retry  <= '0;
            {j, k} <= excite(req_data, q_fb);
            state  <= DRIVE;
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          if (q_fb == target) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry >= RW'(MAX_RETRY)) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            retry  <= retry + RW'(1);
            {j, k} <= excite(target, q_fb);
            state  <= DRIVE;
          end
        end
        ERR: begin
          if (err_clr) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state == DRIVE) || (state == CHECK);

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Bench for jk_drive_ctrl: set/reset and toggle instances each drive a modelled JK bank;
// expected per-cycle outputs are queued by the stimulus and checked by a negedge monitor.
module tb_jk_drive_ctrl;

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic [3:0] j;
    logic [3:0] k;
    logic       done;
    logic       err;
    logic [3:0] q;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid [2];
  logic [3:0] req_data  [2];
  logic       err_clr   [2];
  logic       req_ready [2];
  logic [3:0] j_w       [2];
  logic [3:0] k_w       [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];
  logic [3:0] q_model   [2];
  logic [3:0] stuck     [2];
  logic [3:0] q_fb      [2];

  rec_t exp_q [2][$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  jk_drive_ctrl #(.WIDTH(4), .MAX_RETRY(3), .USE_TOGGLE(0)) u_sr (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_data(req_data[0]),
    .req_ready(req_ready[0]), .q_fb(q_fb[0]), .j(j_w[0]), .k(k_w[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .err_clr(err_clr[0]));

  jk_drive_ctrl #(.WIDTH(4), .MAX_RETRY(3), .USE_TOGGLE(1)) u_tog (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_data(req_data[1]),
    .req_ready(req_ready[1]), .q_fb(q_fb[1]), .j(j_w[1]), .k(k_w[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .err_clr(err_clr[1]));

  // External JK bank model: Qn = J&~Q | ~K&Q, with optional stuck-at-0 bits.
  assign q_fb[0] = q_model[0] & ~stuck[0];
  assign q_fb[1] = q_model[1] & ~stuck[1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      q_model[i] <= (j_w[i] & ~q_fb[i]) | (~k_w[i] & q_fb[i]);
  end

  always @(negedge clk) begin
    rec_t e;
    rec_t a;
    for (int i = 0; i < 2; i++) begin
      a = '{busy[i], req_ready[i], j_w[i], k_w[i], done[i], err[i], q_fb[i]};
      if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cycle inst%0d t=%0t: got busy=%b rdy=%b j=%b k=%b done=%b err=%b q=%b, want busy=%b rdy=%b j=%b k=%b done=%b err=%b q=%b",
                      i, $time, a.busy, a.rdy, a.j, a.k, a.done, a.err, a.q,
                      e.busy, e.rdy, e.j, e.k, e.done, e.err, e.q);
      end else if (done[i] !== 1'b0) begin
        n_checks++;
        $display("FAIL spurious_done inst%0d t=%0t: got done=%b, want 0", i, $time, done[i]);
      end
    end
  end

  function automatic void push(int i, logic b, logic r, logic [3:0] jj, logic [3:0] kk,
                               logic d, logic e, logic [3:0] q);
    rec_t x;
    x = '{b, r, jj, kk, d, e, q};
    exp_q[i].push_back(x);
  endfunction

  // Offers data, returns #1 after the accepting edge with req_valid dropped.
  task automatic run_req(input int i, input logic [3:0] data);
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_data[i]  = data;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_empty(input int i);
    int n = 0;
    while (exp_q[i].size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q[i].size() > 0) begin
      n_checks++;
      $display("FAIL timeout inst%0d: got %0d records pending, want 0", i, exp_q[i].size());
      exp_q[i].delete();
    end
  endtask

  task automatic check_idle(input int i);
    n_checks++;
    if (req_ready[i] === 1'b1 && busy[i] === 1'b0 && j_w[i] === 4'b0 && k_w[i] === 4'b0 &&
        done[i] === 1'b0 && err[i] === 1'b0)
      n_pass++;
    else
      $display("FAIL reset_state inst%0d: got rdy=%b busy=%b j=%b k=%b done=%b err=%b, want 1 0 0000 0000 0 0",
               i, req_ready[i], busy[i], j_w[i], k_w[i], done[i], err[i]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_data[i]  = 4'b0;
      err_clr[i]   = 1'b0;
      q_model[i]   = 4'b0;
      stuck[i]     = 4'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle(0);
    check_idle(1);

    // 0000 -> 1010, req_valid held with other data while busy
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_data[0] = 4'b1010;
    @(posedge clk); #1;
    req_data[0] = 4'b0000;
    push(0, 1, 0, 4'b1010, 4'b0000, 0, 0, 4'b0000);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b1010);
    push(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b1010);
    @(posedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_empty(0);

    // 1010 -> 0110
    run_req(0, 4'b0110);
    push(0, 1, 0, 4'b0100, 4'b1000, 0, 0, 4'b1010);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0110);
    push(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b0110);
    wait_empty(0);

    // target already equal to bank
    run_req(0, 4'b0110);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0110);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0110);
    push(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b0110);
    wait_empty(0);

    // reset during CHECK, req_valid held high throughout, accepted once IDLE
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_data[0] = 4'b1001;
    @(posedge clk); #1;
    push(0, 1, 0, 4'b1001, 4'b0110, 0, 0, 4'b0110);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b1001);
    push(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 4'b1001);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b1001);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b1001);
    push(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b1001);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_empty(0);

    // bit0 stuck at 0: four drives, then ERR until err_clr
    stuck[0] = 4'b0001;
    run_req(0, 4'b0001);
    push(0, 1, 0, 4'b0001, 4'b1000, 0, 0, 4'b1000);
    push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      push(0, 1, 0, 4'b0001, 4'b0000, 0, 0, 4'b0000);
      push(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    end
    push(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    push(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    push(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    repeat (9) @(posedge clk);
    #1 err_clr[0] = 1'b1;
    @(posedge clk); #1 err_clr[0] = 1'b0;
    wait_empty(0);
    stuck[0] = 4'b0000;

    // toggle excitation: 0000 -> 0011 -> 0101
    run_req(1, 4'b0011);
    push(1, 1, 0, 4'b0011, 4'b0011, 0, 0, 4'b0000);
    push(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0011);
    push(1, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b0011);
    wait_empty(1);
    run_req(1, 4'b0101);
    push(1, 1, 0, 4'b0110, 4'b0110, 0, 0, 4'b0011);
    push(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0101);
    push(1, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b0101);
    wait_empty(1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
